// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
// Holds the ALU opcode values, the error-code layout reported by the ALU,
// and the sequencer state encoding.
package alu_pkg;

  // ALU opcodes
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;

  // err_code bit set by the ALU on a zero divisor
  localparam int ERR_DIV0 = 1;

  // err_code reported by the sequencer itself for an opcode above MAX_OP
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_settle_timer.sv
// Loadable down-counter that measures the ALU settle interval.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   load        - load load_value (has priority over enable)
//   load_value  - value loaded into the counter
//   enable      - decrement by one while non-zero
//   zero        - counter currently equals zero
module alu_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         zero
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Registered command front-end for the combinational BreadBoard ALU.
// Accepts one command at a time, drives the ALU from registers, waits
// SETTLE_CYCLES for the result to settle, then presents the captured
// result on a response handshake. Keeps a wrapping command counter and a
// saturating error counter.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            - command handshake
//   cmd_a, cmd_b, cmd_op           - command operands and opcode
//   alu_input1/2, alu_op_code      - registered ALU drive
//   alu_output1, alu_err_code      - ALU result and error code
//   rsp_valid/rsp_ready            - response handshake
//   rsp_result, rsp_err            - captured response
//   cmd_count, err_count           - accepted commands / erroneous responses
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int COUNT_W       = 16,
  parameter int MAX_OP        = int'(OP_MOD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [15:0]        cmd_a,
  input  logic [15:0]        cmd_b,
  input  logic [3:0]         cmd_op,
  output logic [15:0]        alu_input1,
  output logic [15:0]        alu_input2,
  output logic [3:0]         alu_op_code,
  input  logic [31:0]        alu_output1,
  input  logic [1:0]         alu_err_code,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_result,
  output logic [1:0]         rsp_err,
  output logic [COUNT_W-1:0] cmd_count,
  output logic [COUNT_W-1:0] err_count
);

  localparam logic [3:0]         MAX_OP_L    = 4'(MAX_OP);
  // One settle cycle is spent in the accept edge itself.
  localparam logic [7:0]         SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] ONE_C       = {{(COUNT_W-1){1'b0}}, 1'b1};

  seq_state_t         state_reg, state_next;
  logic [15:0]        alu_input1_reg, alu_input1_next;
  logic [15:0]        alu_input2_reg, alu_input2_next;
  logic [3:0]         alu_op_code_reg, alu_op_code_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [31:0]        rsp_result_reg, rsp_result_next;
  logic [1:0]         rsp_err_reg, rsp_err_next;
  logic [COUNT_W-1:0] cmd_count_reg, cmd_count_next;
  logic [COUNT_W-1:0] err_count_reg, err_count_next;
  logic [COUNT_W-1:0] err_count_inc;
  logic               timer_load, timer_enable, timer_zero;

  alu_settle_timer #(.W(8)) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (SETTLE_LOAD),
    .enable     (timer_enable),
    .zero       (timer_zero)
  );

  assign err_count_inc = (err_count_reg == '1) ? err_count_reg : err_count_reg + ONE_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      alu_input1_reg  <= '0;
      alu_input2_reg  <= '0;
      alu_op_code_reg <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_result_reg  <= '0;
      rsp_err_reg     <= '0;
      cmd_count_reg   <= '0;
      err_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      alu_input1_reg  <= alu_input1_next;
      alu_input2_reg  <= alu_input2_next;
      alu_op_code_reg <= alu_op_code_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_result_reg  <= rsp_result_next;
      rsp_err_reg     <= rsp_err_next;
      cmd_count_reg   <= cmd_count_next;
      err_count_reg   <= err_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    alu_input1_next  = alu_input1_reg;
    alu_input2_next  = alu_input2_reg;
    alu_op_code_next = alu_op_code_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_result_next  = rsp_result_reg;
    rsp_err_next     = rsp_err_reg;
    cmd_count_next   = cmd_count_reg;
    err_count_next   = err_count_reg;
    timer_load       = 1'b0;
    timer_enable     = 1'b0;
    cmd_ready        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && cmd_ready) begin
          cmd_count_next = cmd_count_reg + ONE_C;
          if (cmd_op <= MAX_OP_L) begin
            alu_input1_next  = cmd_a;
            alu_input2_next  = cmd_b;
            alu_op_code_next = cmd_op;
            timer_load       = 1'b1;
            state_next       = WAIT;
          end else begin
            // The ALU drive is left alone: the ALU would not produce an
            // output for this opcode, so answer immediately instead.
            rsp_result_next = '0;
            rsp_err_next    = ERR_ILLEGAL;
            rsp_valid_next  = 1'b1;
            err_count_next  = err_count_inc;
            state_next      = RESP;
          end
        end
      end
      WAIT: begin
        timer_enable = 1'b1;
        if (timer_zero) begin
          rsp_result_next = alu_output1;
          rsp_err_next    = alu_err_code;
          rsp_valid_next  = 1'b1;
          if (alu_err_code != 2'b00) begin
            err_count_next = err_count_inc;
          end
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_reg && rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign alu_input1  = alu_input1_reg;
  assign alu_input2  = alu_input2_reg;
  assign alu_op_code = alu_op_code_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_result  = rsp_result_reg;
  assign rsp_err     = rsp_err_reg;
  assign cmd_count   = cmd_count_reg;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU attached.
// Narrow counters (COUNT_W=4) make wrap and saturation reachable quickly.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int S     = 4;
  localparam int CW    = 4;
  localparam int MAXOP = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [15:0]   cmd_a = '0;
  logic [15:0]   cmd_b = '0;
  logic [3:0]    cmd_op = '0;
  logic [15:0]   alu_input1, alu_input2;
  logic [3:0]    alu_op_code;
  logic [31:0]   alu_output1;
  logic [1:0]    alu_err_code;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic [1:0]    rsp_err;
  logic [CW-1:0] cmd_count, err_count;

  int checks = 0;
  int errors = 0;

  // reference state
  int          cmd_m = 0;
  int          err_m = 0;
  logic [15:0] last_a_m = '0;
  logic [15:0] last_b_m = '0;
  logic [3:0]  last_op_m = '0;

  alu_cmd_sequencer #(.SETTLE_CYCLES(S), .COUNT_W(CW), .MAX_OP(MAXOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .alu_input1   (alu_input1),
    .alu_input2   (alu_input2),
    .alu_op_code  (alu_op_code),
    .alu_output1  (alu_output1),
    .alu_err_code (alu_err_code),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_err      (rsp_err),
    .cmd_count    (cmd_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Arithmetic behaviour of the ALU: {err_code, output1}
  function automatic logic [33:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
    logic [31:0] x, y;
    x = {16'd0, a};
    y = {16'd0, b};
    case (op)
      4'd0:    return {2'b00, x + y};
      4'd1:    return {2'b00, x - y};
      4'd2:    return {2'b00, x * y};
      4'd3:    return (b == 16'd0) ? {2'b10, 32'd0} : {2'b00, x / y};
      4'd4:    return (b == 16'd0) ? {2'b10, 32'd0} : {2'b00, x % y};
      default: return {2'b00, 32'hDEAD_BEEF};
    endcase
  endfunction

  always_comb {alu_err_code, alu_output1} = ref_alu(alu_input1, alu_input2, alu_op_code);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bump_err();
    if (err_m < CMAX) err_m++;
  endtask

  // One full command: accept, latency, response, optional back-pressure,
  // optional pre-asserted next command while the response is held.
  task automatic do_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input int delay, input bit preload,
                        input logic [15:0] na, input logic [15:0] nb, input logic [3:0] nop);
    bit          legal;
    logic [31:0] exp_res;
    logic [1:0]  exp_err;
    int          k;
    legal = (op <= 4'(MAXOP));
    @(negedge clk);
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_m = (cmd_m + 1) % (CMAX + 1);
    if (legal) begin
      last_a_m = a;
      last_b_m = b;
      last_op_m = op;
      {exp_err, exp_res} = ref_alu(a, b, op);
    end else begin
      exp_res = 32'd0;
      exp_err = ERR_ILLEGAL;
      bump_err();
    end
    check("alu_op_code", 64'(alu_op_code), 64'(last_op_m));
    check("alu_input1", 64'(alu_input1), 64'(last_a_m));
    check("alu_input2", 64'(alu_input2), 64'(last_b_m));
    check("cmd_count_accept", 64'(cmd_count), 64'(cmd_m));
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    if (legal) begin
      check("rsp_valid_early", 64'(rsp_valid), 64'd0);
      k = 0;
      while (rsp_valid !== 1'b1 && k < 50) begin
        @(posedge clk);
        #1;
        k++;
      end
      check("latency", 64'(k), 64'(S));
      if (exp_err != 2'b00) bump_err();
    end else begin
      check("illegal_latency", 64'(rsp_valid), 64'd1);
    end
    check("rsp_result", 64'(rsp_result), 64'(exp_res));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("err_count", 64'(err_count), 64'(err_m));
    if (preload) begin
      cmd_valid = 1'b1;
      cmd_a = na;
      cmd_b = nb;
      cmd_op = nop;
    end
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_result", 64'(rsp_result), 64'(exp_res));
      check("hold_err", 64'(rsp_err), 64'(exp_err));
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check("hold_cmd_count", 64'(cmd_count), 64'(cmd_m));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("cmd_ready_after", 64'(cmd_ready), 64'd1);
    check("cmd_count_after", 64'(cmd_count), 64'(cmd_m));
    $display("cmd a=%0d b=%0d op=%0d -> result=%0h err=%0b cmd_count=%0d err_count=%0d",
             a, b, op, exp_res, exp_err, cmd_count, err_count);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  rop;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_op", 64'(alu_op_code), 64'd0);
    check("rst_alu_in1", 64'(alu_input1), 64'd0);
    check("rst_cmd_count", 64'(cmd_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_cmd_ready", 64'(cmd_ready), 64'd1);

    // directed
    do_cmd(16'd32000, 16'd16000, OP_DIV, 0, 1'b0, 16'd0, 16'd0, 4'd0);
    do_cmd(16'd11, 16'd0, OP_DIV, 0, 1'b0, 16'd0, 16'd0, 4'd0);
    // back-pressure with the next command already waiting
    do_cmd(16'd1234, 16'd77, OP_MUL, 10, 1'b1, 16'd500, 16'd7, OP_MOD);
    do_cmd(16'd500, 16'd7, OP_MOD, 0, 1'b0, 16'd0, 16'd0, 4'd0);
    // illegal opcode leaves the ALU drive untouched
    do_cmd(16'hAAAA, 16'h5555, 4'b1001, 2, 1'b0, 16'd0, 16'd0, 4'd0);

    // randomized traffic (cmd_count wraps along the way)
    for (int n = 0; n < 30; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      rop = 4'($urandom_range(0, 6));
      if (rop > 4'd4) rop = 4'($urandom_range(5, 15));
      do_cmd(ra, rb, rop, int'($urandom_range(0, 3)), 1'b0, 16'd0, 16'd0, 4'd0);
    end

    // error counter saturation
    for (int n = 0; n < 17; n++) begin
      do_cmd(16'($urandom), 16'd0, OP_DIV, 0, 1'b0, 16'd0, 16'd0, 4'd0);
    end
    check("err_count_saturated", 64'(err_count), 64'(CMAX));

    // reset while waiting on the ALU
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = 16'd9;
    cmd_b = 16'd3;
    cmd_op = OP_ADD;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("midrst_cmd_count", 64'(cmd_count), 64'd0);
    check("midrst_err_count", 64'(err_count), 64'd0);
    check("midrst_alu_op", 64'(alu_op_code), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cmd_m = 0;
    err_m = 0;
    last_a_m = '0;
    last_b_m = '0;
    last_op_m = '0;
    #1;
    check("postrst_cmd_ready", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("postrst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    $display("reset during WAIT: cmd_count=%0d err_count=%0d", cmd_count, err_count);
    do_cmd(16'd40000, 16'd30000, OP_ADD, 1, 1'b0, 16'd0, 16'd0, 4'd0);
    do_cmd(16'd5, 16'd9, OP_SUB, 0, 1'b0, 16'd0, 16'd0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
